// File: rtl/ixu_pkg.sv
// rtl/ixu_pkg.sv - shared op/state encodings and helpers for the IXU multiply/divide unit
package ixu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // The upper half of the encoding is the divide/remainder group
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

  // DIV and REM treat their operands as two's complement
  function automatic logic is_signed_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder rather than the quotient
  function automatic logic is_rem_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/ixu_div_iter.sv
// rtl/ixu_div_iter.sv - restoring divider datapath, one quotient bit per cycle on magnitudes
module ixu_div_iter
  import ixu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic            adv,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] q_nxt,
  output logic [XLEN-1:0] r_nxt,
  output logic            done
);

  localparam int CW = $clog2(XLEN + 1);

  logic            run;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] dsr;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // a clear borrow bit means the divisor fits and the quotient bit is one.
  assign shifted = {rem, quot[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr};
  assign r_nxt   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign q_nxt   = {quot[XLEN-2:0], ~diff[XLEN]};

  // The final iteration's next values are the finished quotient/remainder
  assign done = run && adv && (cnt == CW'(XLEN - 1));

  // Iteration registers: load on start, step when allowed, stop after XLEN steps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run  <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quot <= '0;
      dsr  <= '0;
    end else if (kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run  <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quot <= dividend;
      dsr  <= divisor;
    end else if (run && adv) begin
      rem  <= r_nxt;
      quot <= q_nxt;
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ixu_muldiv.sv
// rtl/ixu_muldiv.sv - pipelined multiply and iterative divide unit for the IXU lane
module ixu_muldiv #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            squash,
  input  logic            valid_in,
  input  logic [2:0]      op,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            valid_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] data_out,
  output logic            wr_en
);

  import ixu_pkg::*;

  div_state_e state;

  logic [MUL_STAGES-1:0]           stg_v;
  logic [MUL_STAGES-1:0][4:0]      stg_rd;
  logic [MUL_STAGES-1:0][XLEN-1:0] stg_data;
  logic                            wr_q;

  logic div_op, div_signed, div_rem;
  logic accept, mul_acc, div_acc;
  logic b_zero, a_min, b_m1, ovf;
  logic div_special, div_start, div_done, div_load;
  logic a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, spec_data;
  logic [XLEN-1:0] q_nxt, r_nxt, q_fix, r_fix;
  logic [4:0]      div_rd_res;
  logic [XLEN-1:0] div_data_res;

  logic [4:0] rd_q;
  logic       neg_q_q, neg_r_q, rem_q;

  logic            a_sx, b_sx;
  logic [2*XLEN-1:0] ea, eb, prod;
  logic [XLEN-1:0]   mul_res;

  assign div_op     = is_div_op(op);
  assign div_signed = is_signed_div(op);
  assign div_rem    = is_rem_op(op);

  // A divide must wait for the multiply pipe to drain so results never collide
  assign busy    = (state != ST_IDLE) || (valid_in && div_op && (|stg_v));
  assign accept  = valid_in && !busy && !stall && !squash;
  assign mul_acc = accept && !div_op;
  assign div_acc = accept && div_op;

  // Divide-by-zero and signed overflow bypass the iteration entirely
  assign b_zero      = (b == '0);
  assign a_min       = (a == {1'b1, {(XLEN-1){1'b0}}});
  assign b_m1        = &b;
  assign ovf         = div_signed && a_min && b_m1;
  assign div_special = div_acc && (b_zero || ovf);
  assign div_start   = div_acc && !(b_zero || ovf);
  assign spec_data   = div_rem ? (b_zero ? a : '0) : (b_zero ? '1 : a);

  assign a_neg = div_signed & a[XLEN-1];
  assign b_neg = div_signed & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Remember the sign fix-up and destination for the divide in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      rem_q   <= 1'b0;
    end else if (div_start) begin
      rd_q    <= rd_in;
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      rem_q   <= div_rem;
    end
  end

  ixu_div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .kill     (squash),
    .adv      (~stall),
    .dividend (a_mag),
    .divisor  (b_mag),
    .q_nxt    (q_nxt),
    .r_nxt    (r_nxt),
    .done     (div_done)
  );

  assign q_fix        = neg_q_q ? -q_nxt : q_nxt;
  assign r_fix        = neg_r_q ? -r_nxt : r_nxt;
  assign div_load     = div_special | div_done;
  assign div_rd_res   = div_special ? rd_in : rd_q;
  assign div_data_res = div_special ? spec_data : (rem_q ? r_fix : q_fix);

  // Divide FSM: squash wins over stall, stall freezes everything else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (squash) begin
      state <= ST_IDLE;
    end else if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (div_special)    state <= ST_DONE;
          else if (div_start) state <= ST_DIV;
        end
        ST_DIV: begin
          if (div_done) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Full-width product; sign-extending into 2*XLEN bits makes the low half exact
  assign a_sx    = (op == OP_MULH) || (op == OP_MULHSU);
  assign b_sx    = (op == OP_MULH);
  assign ea      = {{XLEN{a_sx & a[XLEN-1]}}, a};
  assign eb      = {{XLEN{b_sx & b[XLEN-1]}}, b};
  assign prod    = ea * eb;
  assign mul_res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Multiply pipe; the final stage doubles as the output register and also
  // takes divide results, which can only arrive while the pipe is empty.
  for (genvar s = 0; s < MUL_STAGES; s++) begin : g_stage
    logic            v_in, v_d, v_q;
    logic [4:0]      rd_in_s, rd_d, rd_q_s;
    logic [XLEN-1:0] data_in_s, data_d, data_q;

    if (s == 0) begin : g_head
      assign v_in      = mul_acc;
      assign rd_in_s   = rd_in;
      assign data_in_s = mul_res;
    end else begin : g_body
      assign v_in      = stg_v[s-1];
      assign rd_in_s   = stg_rd[s-1];
      assign data_in_s = stg_data[s-1];
    end

    if (s == MUL_STAGES - 1) begin : g_tail
      assign v_d    = v_in | div_load;
      assign rd_d   = div_load ? div_rd_res : rd_in_s;
      assign data_d = div_load ? div_data_res : data_in_s;

      // Write enable is registered beside the result so it is flop-driven too
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        wr_q <= 1'b0;
        else if (squash) wr_q <= 1'b0;
        else if (!stall) wr_q <= v_d && (rd_d != 5'd0);
      end
    end else begin : g_mid
      assign v_d    = v_in;
      assign rd_d   = rd_in_s;
      assign data_d = data_in_s;
    end

    // Stage register: squash empties it, stall holds it
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q    <= 1'b0;
        rd_q_s <= '0;
        data_q <= '0;
      end else if (squash) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q    <= v_d;
        rd_q_s <= rd_d;
        data_q <= data_d;
      end
    end

    assign stg_v[s]    = v_q;
    assign stg_rd[s]   = rd_q_s;
    assign stg_data[s] = data_q;
  end

  assign valid_out = stg_v[MUL_STAGES-1];
  assign rd_out    = stg_rd[MUL_STAGES-1];
  assign data_out  = stg_data[MUL_STAGES-1];
  assign wr_en     = wr_q;

endmodule
